// File: rtl/ws2812b_pkg.sv
// Register map, STATUS layout, color payload and FSM encoding for the WS2812B feeder.
// WS2812B_BRIGHTNESS_EN adds the per-channel brightness scaling helpers.
package ws2812b_pkg;

  localparam int unsigned COLOR_W = 24;
  localparam int unsigned BUS_W   = 32;

  localparam logic [1:0] REG_COLOR   = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_REFRESH = 2'd3;

  localparam int unsigned STAT_FULL       = 0;
  localparam int unsigned STAT_EMPTY      = 1;
  localparam int unsigned STAT_CAN_ACCEPT = 2;
  localparam int unsigned STAT_COUNT_LSB  = 3;
  localparam int unsigned STAT_COUNT_W    = 4;
  localparam int unsigned STAT_OVF        = 8;

  localparam int unsigned CTRL_AUTO_REFRESH = 8;
  localparam logic [7:0]  BRIGHTNESS_RESET  = 8'hFF;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCALE = 2'd1,
    ST_OFFER = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

`ifdef WS2812B_BRIGHTNESS_EN
  // (c * (bright + 1)) >> 8, so bright = 255 is the identity.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] bright);
    logic [15:0] prod;
    prod = 16'(c) * (16'(bright) + 16'd1);
    return 8'(prod >> 8);
  endfunction

  function automatic grb_t scale_grb(input grb_t c, input logic [7:0] bright);
    grb_t s;
    s.g = scale_chan(c.g, bright);
    s.r = scale_chan(c.r, bright);
    s.b = scale_chan(c.b, bright);
    return s;
  endfunction
`endif

endpackage

// File: rtl/ws2812b_fifo.sv
// Synchronous color FIFO with occupancy count and registered full/empty flags.
// A push while full is accepted when a pop happens in the same cycle.
module ws2812b_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_nxt;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ws2812b_feeder.sv
// Bus-programmable color feeder for a WS2812B LED driver: FIFO, registers, refresh timer, handoff FSM.
// Define WS2812B_BRIGHTNESS_EN to enable brightness scaling through CTRL[7:0].
module ws2812b_feeder
  import ws2812b_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter logic [23:0] REFRESH_DEFAULT = 24'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  wstrb,
  input  logic [1:0]  addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready,
  input  logic        can_accept,
  output logic [23:0] led_data,
  output logic        led_ena
);

  localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  logic               access;
  logic               is_read;
  logic               is_write;
  logic               color_wr;
  logic               color_push;
  logic               ctrl_wr;
  logic               refresh_wr;
  logic               ovf_set;
  logic               ovf_clr;
  logic               ovf;
  logic               auto_refresh;
  logic [23:0]        refresh;
  logic [23:0]        refresh_nxt;
  logic [23:0]        refresh_cnt;
  logic               refresh_due;
  logic [COLOR_W-1:0] last_pushed;
  logic [BUS_W-1:0]   status_word;
  logic [BUS_W-1:0]   rd_word;
  logic               offer_take;
  logic               unused_bits;
`ifdef WS2812B_BRIGHTNESS_EN
  logic [7:0]         brightness;
`endif

  state_t             state;
  grb_t               cur_color;
  grb_t               last_sent;
  grb_t               scaled;

  logic               fifo_pop;
  logic [COLOR_W-1:0] fifo_head;
  logic [FIFO_CW-1:0] fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  assign unused_bits = ^{data_i[31:24], fifo_count};

  // One access per sel assertion: it completes on the edge that raises ready.
  assign access     = sel && !ready;
  assign is_write   = access && (wstrb != 4'b0000);
  assign is_read    = access && (wstrb == 4'b0000);
  assign color_wr   = is_write && (addr == REG_COLOR) && wstrb[0];
  assign ctrl_wr    = is_write && (addr == REG_CTRL);
  assign refresh_wr = is_write && (addr == REG_REFRESH);
  assign ovf_clr    = is_write && (addr == REG_STATUS) && wstrb[1] && data_i[STAT_OVF];

  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
  assign color_push = color_wr && (!fifo_full || fifo_pop);
  assign ovf_set    = color_wr && fifo_full && !fifo_pop;

  assign offer_take  = (state == ST_OFFER) && can_accept;
  assign led_ena     = offer_take;
  assign refresh_due = auto_refresh && (refresh != '0) && (refresh_cnt == '0);

  ws2812b_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (COLOR_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (color_wr),
    .pop    (fifo_pop),
    .wdata  (data_i[COLOR_W-1:0]),
    .head_c (fifo_head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    refresh_nxt = refresh;
    for (int i = 0; i < 3; i++) begin
      if (wstrb[i]) refresh_nxt[8*i +: 8] = data_i[8*i +: 8];
    end
  end

  always_comb begin
    status_word                                  = '0;
    status_word[STAT_FULL]                       = fifo_full;
    status_word[STAT_EMPTY]                      = fifo_empty;
    status_word[STAT_CAN_ACCEPT]                 = can_accept;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W]  = STAT_COUNT_W'(fifo_count);
    status_word[STAT_OVF]                        = ovf;
  end

  always_comb begin
    rd_word = '0;
    case (addr)
      REG_COLOR:   rd_word = BUS_W'(last_pushed);
      REG_CTRL: begin
        rd_word[CTRL_AUTO_REFRESH] = auto_refresh;
`ifdef WS2812B_BRIGHTNESS_EN
        rd_word[7:0] = brightness;
`endif
      end
      REG_STATUS:  rd_word = status_word;
      REG_REFRESH: rd_word = BUS_W'(refresh);
    endcase
  end

`ifdef WS2812B_BRIGHTNESS_EN
  assign scaled = scale_grb(cur_color, brightness);
`else
  assign scaled = cur_color;
`endif

  // Bus-side registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready        <= 1'b0;
      data_o       <= '0;
      ovf          <= 1'b0;
      last_pushed  <= '0;
      auto_refresh <= 1'b0;
      refresh      <= REFRESH_DEFAULT;
`ifdef WS2812B_BRIGHTNESS_EN
      brightness   <= BRIGHTNESS_RESET;
`endif
    end else begin
      ready <= access;
      if (access) data_o <= is_read ? rd_word : '0;
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (color_push) last_pushed <= data_i[COLOR_W-1:0];
      if (ctrl_wr) begin
        if (wstrb[1]) auto_refresh <= data_i[CTRL_AUTO_REFRESH];
`ifdef WS2812B_BRIGHTNESS_EN
        if (wstrb[0]) brightness <= data_i[7:0];
`endif
      end
      if (refresh_wr) refresh <= refresh_nxt;
    end
  end

  // Handoff FSM and refresh timer; led_data only changes when leaving SCALE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      led_data    <= '0;
      cur_color   <= '0;
      last_sent   <= '0;
      refresh_cnt <= '0;
    end else begin
      if (refresh_wr) begin
        refresh_cnt <= refresh_nxt;
      end else if (offer_take) begin
        refresh_cnt <= refresh;
      end else if (refresh_cnt != '0) begin
        refresh_cnt <= refresh_cnt - 24'(1);
      end

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_color <= fifo_head;
            state     <= ST_SCALE;
          end else if (refresh_due) begin
            cur_color <= last_sent;
            state     <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          led_data <= scaled;
          state    <= ST_OFFER;
        end
        ST_OFFER: begin
          if (can_accept) begin
            last_sent <= cur_color;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_feeder.sv
// Directed self-checking bench for ws2812b_feeder (default FIFO depth 4, REFRESH reset 0).
module tb_ws2812b_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [3:0]  wstrb;
  logic [1:0]  addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ready;
  logic        can_accept;
  logic [23:0] led_data;
  logic        led_ena;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          ena_cnt = 0;
  logic [23:0] ena_color[$];
  int          ena_cyc[$];

`ifdef WS2812B_BRIGHTNESS_EN
  localparam logic [31:0] CTRL_RST  = 32'h0000_00FF;
  localparam logic [31:0] CTRL_7F   = 32'h0000_007F;
  localparam logic [31:0] EXP_B7F   = 32'h0040_2010;
  localparam logic [31:0] EXP_B00   = 32'h0000_0000;
`else
  localparam logic [31:0] CTRL_RST  = 32'h0000_0000;
  localparam logic [31:0] CTRL_7F   = 32'h0000_0000;
  localparam logic [31:0] EXP_B7F   = 32'h0080_4020;
  localparam logic [31:0] EXP_B00   = 32'h00FF_FFFF;
`endif

  ws2812b_feeder #(
    .FIFO_DEPTH      (4),
    .REFRESH_DEFAULT (24'd0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .wstrb      (wstrb),
    .addr       (addr),
    .data_i     (data_i),
    .data_o     (data_o),
    .ready      (ready),
    .can_accept (can_accept),
    .led_data   (led_data),
    .led_ena    (led_ena)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (led_ena) begin
      ena_cnt++;
      ena_color.push_back(led_data);
      ena_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] color_at(input int i);
    if (i < ena_color.size()) return 32'(ena_color[i]);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < ena_cyc.size()) return ena_cyc[i];
    return -1;
  endfunction

  task automatic bus_access(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                            output logic [31:0] q);
    int n = 0;
    sel = 1'b1; addr = a; wstrb = s; data_i = d;
    @(negedge clk);
    while (!ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check_eq("bus_ready_timeout", 32'(ready), 32'h1);
    q = data_o;
    tick(1);
    sel = 1'b0; wstrb = 4'h0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] q;
    bus_access(a, s, d, q);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] q);
    bus_access(a, 4'h0, 32'h0, q);
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    int n = 0;
    while (ena_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    check_eq(tag, 32'(ena_cnt), 32'(target));
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] drain_exp [5];
    reset = 1'b1; sel = 1'b0; wstrb = 4'h0; addr = 2'd0; data_i = '0; can_accept = 1'b0;
    tick(3);
    check_eq("rst_led_ena", 32'(led_ena), 32'h0);
    check_eq("rst_led_data", 32'(led_data), 32'h0);
    check_eq("rst_ready", 32'(ready), 32'h0);
    check_eq("rst_data_o", data_o, 32'h0);
    reset = 1'b0;
    tick(1);

    bus_read(2'd2, q); check_eq("status_reset", q, 32'h0000_0002);
    check_eq("ready_single_cycle", 32'(ready), 32'h0);
    bus_read(2'd1, q); check_eq("ctrl_reset", q, CTRL_RST);
    bus_read(2'd3, q); check_eq("refresh_reset", q, 32'h0);

    // Single color, full brightness.
    can_accept = 1'b1;
    bus_write(2'd0, 4'hF, 32'h0000_FF00);
    wait_pulses("basic_pulse", 1, 20);
    check_eq("basic_color", color_at(0), 32'h0000_FF00);
    tick(30);
    check_eq("basic_no_repeat", 32'(ena_cnt), 32'd1);
    bus_read(2'd0, q); check_eq("color_readback", q, 32'h0000_FF00);

    // Brightness 0x7F and 0x00.
    bus_write(2'd1, 4'h1, 32'h0000_007F);
    bus_read(2'd1, q); check_eq("ctrl_bright_rd", q, CTRL_7F);
    bus_write(2'd0, 4'hF, 32'h0080_4020);
    wait_pulses("scale7f_pulse", 2, 20);
    check_eq("scale7f_color", color_at(1), EXP_B7F);
    bus_write(2'd1, 4'h1, 32'h0000_0000);
    bus_write(2'd0, 4'hF, 32'h00FF_FFFF);
    wait_pulses("scale00_pulse", 3, 20);
    check_eq("scale00_color", color_at(2), EXP_B00);
    bus_write(2'd1, 4'h1, 32'h0000_00FF);

    // Stalled driver: A1 is held in OFFER, B0..B3 fill the FIFO, B4 overflows.
    can_accept = 1'b0;
    bus_write(2'd0, 4'hF, 32'h0000_00A1);
    for (int i = 0; i < 5; i++) bus_write(2'd0, 4'hF, 32'h0000_00B0 + 32'(i));
    bus_read(2'd2, q); check_eq("status_full_ovf", q, 32'h0000_0121);
    bus_read(2'd0, q); check_eq("color_last_pushed", q, 32'h0000_00B3);
    check_eq("stall_no_pulse", 32'(ena_cnt), 32'd3);
    bus_write(2'd2, 4'hF, 32'h0000_0100);
    bus_read(2'd2, q); check_eq("status_ovf_clr", q, 32'h0000_0021);

    // Release A1; the COLOR write lands on the same edge IDLE pops B0.
    can_accept = 1'b1;
    tick(1);
    can_accept = 1'b0;
    tick(1);
    bus_write(2'd0, 4'hF, 32'h0000_00C0);
    bus_read(2'd2, q); check_eq("status_push_pop_full", q, 32'h0000_0021);
    check_eq("release_pulse", 32'(ena_cnt), 32'd4);
    check_eq("release_color", color_at(3), 32'h0000_00A1);

    can_accept = 1'b1;
    wait_pulses("drain_pulses", 9, 200);
    drain_exp = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hC0};
    for (int i = 0; i < 5; i++) check_eq($sformatf("drain_color%0d", i), color_at(4 + i), drain_exp[i]);
    bus_read(2'd2, q); check_eq("status_drained", q, 32'h0000_0006);

    // Auto refresh every 100 clocks: reload at accept, 101 cycles to reach IDLE with 0, +2 to OFFER.
    bus_write(2'd3, 4'hF, 32'd100);
    bus_write(2'd1, 4'h3, 32'h0000_01FF);
    bus_write(2'd0, 4'hF, 32'h0012_3456);
    wait_pulses("refresh_pulses", 12, 400);
    for (int i = 9; i < 12; i++) check_eq($sformatf("refresh_color%0d", i), color_at(i), 32'h0012_3456);
    check_eq("refresh_gap1", 32'(cyc_at(10) - cyc_at(9)), 32'd103);
    check_eq("refresh_gap2", 32'(cyc_at(11) - cyc_at(10)), 32'd103);
    bus_write(2'd1, 4'h2, 32'h0000_0000);
    tick(250);
    check_eq("refresh_off", 32'(ena_cnt), 32'd12);

    // Reset while a color waits in OFFER.
    can_accept = 1'b0;
    bus_write(2'd0, 4'hF, 32'h00AB_CDEF);
    bus_read(2'd2, q); check_eq("pre_reset_status", q, 32'h0000_0002);
    tick(2);
    check_eq("pre_reset_led_data", 32'(led_data), 32'h00AB_CDEF);
    reset = 1'b1;
    #2;
    check_eq("midrst_led_ena", 32'(led_ena), 32'h0);
    check_eq("midrst_led_data", 32'(led_data), 32'h0);
    check_eq("midrst_ready", 32'(ready), 32'h0);
    check_eq("midrst_data_o", data_o, 32'h0);
    tick(2);
    reset = 1'b0;
    can_accept = 1'b1;
    tick(30);
    check_eq("midrst_no_pulse", 32'(ena_cnt), 32'd12);
    bus_read(2'd2, q); check_eq("midrst_status", q, 32'h0000_0006);
    bus_read(2'd1, q); check_eq("midrst_ctrl", q, CTRL_RST);
    bus_read(2'd0, q); check_eq("midrst_color", q, 32'h0);
    bus_read(2'd3, q); check_eq("midrst_refresh", q, 32'h0);

    // REFRESH byte strobes.
    bus_write(2'd3, 4'b0010, 32'h00AB_CDEF);
    bus_read(2'd3, q); check_eq("refresh_bytestrobe", q, 32'h0000_CD00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
